// File: rtl/precision_farming_asic_if.sv
// Pad-level bus of the precision-farming controller.
// The bench drives the master side; the core sits on the slave side.
interface precision_farming_asic_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    modport master (
        output ena, ui_in, uio_in,
        input  uio_out, uio_oe, uo_out
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uio_out, uio_oe, uo_out
    );
endinterface

// File: rtl/precision_farming_asic.sv
// Precision-farming controller: sensor baseline grading (mode 0)
// and camera/ultrasonic harvest-readiness network (mode 1).
module precision_farming_asic #(
    parameter int SAMPLE_DIV  = 8,
    parameter int TRIG_PERIOD = 65536,
    parameter int TRIG_WIDTH  = 256
) (
    input logic clk,
    input logic rst,
    precision_farming_asic_if.slave bus
);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(TRIG_PERIOD);

    logic       mode;
    logic       vsync;
    logic       href;
    logic       echo;
    logic [1:0] sel;
    logic [7:0] din;

    assign mode  = bus.uio_in[7];
    assign vsync = bus.uio_in[6];
    assign href  = bus.uio_in[5];
    assign echo  = bus.uio_in[3];
    assign sel   = bus.uio_in[1:0];
    assign din   = bus.ui_in;

    // ---------------- sensor path ----------------
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [9:0]    sum;
    logic [9:0]    sum_nxt;
    logic [1:0]    scnt;
    logic [1:0]    sel_q;
    logic [3:0]    valid;
    logic [7:0]    base [4];
    logic [2:0]    level;
    logic [7:0]    avg;
    logic [7:0]    dev;

    assign tick    = (div_cnt == DW'(SAMPLE_DIV - 1));
    assign sum_nxt = sum + {2'b00, din};
    assign avg     = sum_nxt[9:2];
    assign dev     = (avg >= base[sel]) ? (avg - base[sel])
                                        : (base[sel] - avg);

    function automatic logic [2:0] grade(input logic [7:0] d);
        logic [2:0] g;
        g = 3'd0;
        if (d >= 8'd128)     g = 3'd5;
        else if (d >= 8'd64) g = 3'd4;
        else if (d >= 8'd32) g = 3'd3;
        else if (d >= 8'd16) g = 3'd2;
        else if (d >= 8'd8)  g = 3'd1;
        return g;
    endfunction

    // Free-running sample divider, independent of mode.
    always_ff @(posedge clk) begin
        if (rst) div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else div_cnt <= div_cnt + 1'b1;
    end

    // 4-sample averaging, baseline learning and deviation grading.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            scnt  <= '0;
            sel_q <= '0;
            valid <= '0;
            level <= '0;
            for (int i = 0; i < 4; i++) base[i] <= '0;
        end else begin
            sel_q <= sel;
            if (!mode) begin
                if (sel != sel_q) begin
                    sum  <= '0;
                    scnt <= '0;
                end else if (tick) begin
                    if (scnt == 2'd3) begin
                        sum  <= '0;
                        scnt <= '0;
                        if (!valid[sel]) begin
                            base[sel]  <= avg;
                            valid[sel] <= 1'b1;
                            level      <= 3'd0;
                        end else begin
                            level <= grade(dev);
                        end
                    end else begin
                        sum  <= sum_nxt;
                        scnt <= scnt + 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- camera / echo / network ----------------
    logic        vsync_q;
    logic        href_q;
    logic        echo_q;
    logic        phase;
    logic [7:0]  b0;
    logic [15:0] pixel_cnt;
    logic [15:0] green_cnt;
    logic [15:0] echo_cnt;
    logic        height_ok;
    logic        ready;
    logic [2:0]  h;
    logic        pred;
    logic [4:0]  pr;
    logic [4:0]  pg;
    logic [4:0]  pb;
    logic        green;
    logic [17:0] g4;
    logic [17:0] p3;
    logic        f0;
    logic        f1;
    logic        f2;
    logic [2:0]  h_nxt;
    logic        pred_nxt;

    assign pr    = b0[7:3];
    assign pg    = {b0[2:0], din[7:6]};
    assign pb    = din[4:0];
    assign green = (pg > pr) && (pg > pb);

    assign g4 = {green_cnt, 2'b00};
    assign p3 = {2'b00, pixel_cnt} + {1'b0, pixel_cnt, 1'b0};
    assign f0 = (pixel_cnt != 16'd0) && (g4 >= p3);
    assign f1 = (green_cnt >= 16'd256);
    assign f2 = height_ok;

    assign h_nxt[0] = f0 & f1;
    assign h_nxt[1] = f1 & f2;
    assign h_nxt[2] = ({1'b0, f0} + {1'b0, f1} + {1'b0, f2}) >= 2'd2;
    assign pred_nxt = ({1'b0, h_nxt[0]} + {1'b0, h_nxt[1]}
                     + {1'b0, h_nxt[2]}) >= 2'd2;

    // Frame capture, green counting and network evaluation on vsync fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            phase     <= 1'b0;
            b0        <= '0;
            pixel_cnt <= '0;
            green_cnt <= '0;
            ready     <= 1'b0;
            h         <= '0;
            pred      <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
            if (mode) begin
                if (vsync && !vsync_q) begin
                    pixel_cnt <= '0;
                    green_cnt <= '0;
                    phase     <= 1'b0;
                    ready     <= 1'b0;
                end else if (vsync && href) begin
                    phase <= ~phase;
                    if (!phase) begin
                        b0 <= din;
                    end else begin
                        if (pixel_cnt != 16'hFFFF)
                            pixel_cnt <= pixel_cnt + 1'b1;
                        if (green && green_cnt != 16'hFFFF)
                            green_cnt <= green_cnt + 1'b1;
                    end
                end else if (!href && href_q) begin
                    phase <= 1'b0;
                end
                if (!vsync && vsync_q) begin
                    h     <= h_nxt;
                    pred  <= pred_nxt;
                    ready <= 1'b1;
                end
            end
        end
    end

    // Ultrasonic echo width measurement and plant-height window.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_q    <= 1'b0;
            echo_cnt  <= '0;
            height_ok <= 1'b0;
        end else begin
            echo_q <= echo;
            if (mode) begin
                if (echo) begin
                    if (echo_cnt != 16'hFFFF)
                        echo_cnt <= echo_cnt + 1'b1;
                end else if (echo_q) begin
                    height_ok <= (echo_cnt >= 16'd32)
                              && (echo_cnt < 16'd1024);
                    echo_cnt  <= '0;
                end
            end
        end
    end

    // ---------------- trigger, XCLK and output mux ----------------
    logic [TW-1:0] trig_cnt;
    logic          trig;
    logic          xclk;
    logic [7:0]    uo_q;
    logic [7:0]    uio_q;
    logic          alert;
    logic          critical;

    assign trig     = (trig_cnt < TW'(TRIG_WIDTH));
    assign alert    = (level >= 3'd2);
    assign critical = (level >= 3'd4);

    // Trigger period counter.
    always_ff @(posedge clk) begin
        if (rst) trig_cnt <= '0;
        else if (trig_cnt == TW'(TRIG_PERIOD - 1)) trig_cnt <= '0;
        else trig_cnt <= trig_cnt + 1'b1;
    end

    // Registered output mux selected by the current mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            xclk  <= 1'b0;
            uo_q  <= '0;
            uio_q <= '0;
        end else begin
            xclk <= ~xclk;
            if (mode) begin
                uo_q  <= {pred, ready, 1'b1, pred, h, height_ok};
                uio_q <= {3'b000, xclk, 2'b00, trig, 1'b0};
            end else begin
                uo_q  <= {alert, valid[sel], 1'b0, critical,
                          level, sel[0]};
                uio_q <= {6'b000000, sel[1], 1'b0};
            end
        end
    end

    assign bus.uo_out  = uo_q;
    assign bus.uio_out = uio_q;
    assign bus.uio_oe  = 8'b0001_0010;

    logic unused;
    assign unused = &{1'b0, bus.ena, bus.uio_in[4], bus.uio_in[2],
                      sum_nxt[1:0]};
endmodule

// File: tb/tb_precision_farming_asic.sv
// Directed bench for precision_farming_asic: sensor grading,
// camera/echo network, mode switching and trigger timing.
module tb_precision_farming_asic;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    logic a;

    precision_farming_asic_if bus ();

    precision_farming_asic dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rows(input int n, input logic [7:0] first);
        for (int r = 0; r < n; r++) begin
            bus.uio_in[5] = 1'b1;
            for (int i = 0; i < 40; i++) begin
                bus.ui_in = i[0] ? 8'hF0 : first;
                step(1);
            end
            bus.uio_in[5] = 1'b0;
            step(4);
        end
    endtask

    task automatic pulse_echo(input int n);
        bus.uio_in[3] = 1'b1;
        step(n);
        bus.uio_in[3] = 1'b0;
        step(3);
    endtask

    initial begin
        bus.ena    = 1'b1;
        bus.ui_in  = 8'd100;
        bus.uio_in = 8'h00;
        step(5);
        chk("rst_uo", bus.uo_out, 8'h00);
        chk("rst_uio", bus.uio_out, 8'h00);
        chk("rst_oe", bus.uio_oe, 8'h12);
        rst = 1'b0;
        step(2);
        chk("post_rst_uo", bus.uo_out, 8'h00);

        // sensor 0: baseline 100, then 130 (dev 30) and 180 (dev 80)
        step(88);
        chk("s0_base", bus.uo_out, 8'h40);
        bus.ui_in = 8'd130;
        step(90);
        chk("s0_lvl2", bus.uo_out, 8'hC4);
        bus.ui_in = 8'd180;
        step(90);
        chk("s0_lvl4", bus.uo_out, 8'hD8);

        // sensors 1..3: baseline v, then v+40 -> level 3
        bus.uio_in[1:0] = 2'd1;
        bus.ui_in = 8'd50;
        step(90);
        chk("s1_base", bus.uo_out, 8'h41);
        chk("s1_uio", bus.uio_out, 8'h00);
        bus.ui_in = 8'd90;
        step(90);
        chk("s1_lvl3", bus.uo_out, 8'hC7);

        bus.uio_in[1:0] = 2'd2;
        bus.ui_in = 8'd60;
        step(90);
        chk("s2_base", bus.uo_out, 8'h40);
        chk("s2_uio", bus.uio_out, 8'h02);
        bus.ui_in = 8'd100;
        step(90);
        chk("s2_lvl3", bus.uo_out, 8'hC6);

        bus.uio_in[1:0] = 2'd3;
        bus.ui_in = 8'd70;
        step(90);
        chk("s3_base", bus.uo_out, 8'h41);
        bus.ui_in = 8'd110;
        step(90);
        chk("s3_lvl3", bus.uo_out, 8'hC7);
        chk("s3_uio", bus.uio_out, 8'h02);

        // ML mode idle
        bus.uio_in[7] = 1'b1;
        step(3);
        chk("ml_idle", bus.uo_out, 8'h20);
        chk("ml_uio_zero", bus.uio_out & 8'hED, 8'h00);
        chk("ml_trig_lo", bus.uio_out & 8'h02, 8'h00);
        a = bus.uio_out[4];
        step(1);
        chk("xclk_tog", {7'b0, bus.uio_out[4]}, {7'b0, ~a});

        // frame 1: 200 green pixels, no echo -> f0 only
        bus.uio_in[6] = 1'b1;
        step(2);
        rows(10, 8'h47);
        bus.uio_in[6] = 1'b0;
        step(20);
        chk("f1_result", bus.uo_out, 8'h60);

        // echo 100 cycles -> height_ok
        pulse_echo(100);
        chk("echo100", bus.uo_out, 8'h61);

        // frame 2: 1000 green pixels -> all features
        bus.uio_in[6] = 1'b1;
        step(3);
        chk("vs_rise_clr", bus.uo_out, 8'h21);
        rows(50, 8'h17);
        bus.uio_in[6] = 1'b0;
        step(20);
        chk("f2_result", bus.uo_out, 8'hFF);

        // echo width window edges
        pulse_echo(31);
        chk("echo31", bus.uo_out, 8'hFE);
        pulse_echo(32);
        chk("echo32", bus.uo_out, 8'hFF);
        pulse_echo(1024);
        chk("echo1024", bus.uo_out, 8'hFE);
        pulse_echo(1023);
        chk("echo1023", bus.uo_out, 8'hFF);

        // back to sensor mode: state retained
        bus.uio_in[7] = 1'b0;
        bus.ui_in = 8'd110;
        step(2);
        chk("mode0_uo", bus.uo_out, 8'hC7);
        chk("mode0_uio", bus.uio_out, 8'h02);
        chk("mode0_oe", bus.uio_oe, 8'h12);
        bus.uio_in[1:0] = 2'd0;
        bus.ui_in = 8'd180;
        step(90);
        chk("s0_retained", bus.uo_out, 8'hD8);

        // ML again: results retained, trigger in second period
        bus.uio_in[7] = 1'b1;
        step(2);
        chk("mode1_uo", bus.uo_out, 8'hFF);
        while (cyc < 65650) step(1);
        chk("trig_hi", bus.uio_out & 8'h02, 8'h02);
        while (cyc < 65900) step(1);
        chk("trig_lo", bus.uio_out & 8'h02, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
